// File: rtl/sci_host_master.sv
// Host-side end of the SCI serial link.
// Generates the free-running serial clock, serialises bytes from a valid/ready
// stream onto sci_txd (gated by the core's ready line), and deserialises
// sci_rxd into a single-entry output register that drives host flow control.
module sci_host_master #(
    parameter int CLKDIV = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    output logic       sci_sclk,
    output logic       sci_txd,
    input  logic       sci_txr_n,
    input  logic       sci_rxd,
    output logic       sci_rxr_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

    // Serial clock divider
    logic [15:0] div_cnt_q, div_cnt_d;
    logic        sclk_q, sclk_d;
    logic        div_tc, rise_ev, fall_ev;

    // Input synchronisers
    logic txr_meta_q, txr_s_q;
    logic rxd_meta_q, rxd_s_q;

    // Transmit path
    tx_state_t   tx_state_q, tx_state_d;
    logic        txd_q, txd_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        in_ready_q, in_ready_d;
    logic        tx_accept, tx_start_ok;

    // Receive path
    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        rxr_n_q, rxr_n_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    // Divider: toggle sclk at terminal count; edge strobes mark the toggle cycle
    always_comb begin
        div_tc    = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_tc ? 16'd0 : div_cnt_q + 16'd1;
        sclk_d    = div_tc ? ~sclk_q : sclk_q;
        rise_ev   = div_tc & ~sclk_q;
        fall_ev   = div_tc & sclk_q;
    end

    // Transmit holding register and frame sequencer, advancing on sclk falls
    always_comb begin
        tx_state_d  = tx_state_q;
        txd_d       = txd_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_accept   = in_valid & in_ready_q;
        tx_start_ok = hold_full_q & ~txr_s_q;

        // Accept only happens with the holding register empty, so it never
        // collides with a frame start draining the register in the same cycle.
        if (tx_accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (fall_ev) begin
            unique case (tx_state_q)
                TX_IDLE, TX_STOP: begin
                    // Starting straight from STOP keeps frames back-to-back.
                    if (tx_start_ok) begin
                        txd_d       = 1'b0;
                        tx_shift_d  = hold_q;
                        hold_full_d = 1'b0;
                        tx_state_d  = TX_START;
                    end else begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end
                TX_START: begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_cnt_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_cnt_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_cnt_d   = tx_cnt_q + 3'd1;
                    end
                end
                default: begin
                    txd_d      = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            endcase
        end

        in_ready_d = ~hold_full_d;
    end

    // Receive deserialiser sampling on sclk rises, plus output register handshake
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end

        if (rise_ev) begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rxd_s_q) begin
                        rx_cnt_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Loading only into an empty register means a load can
                    // never coincide with the consumer taking the old byte.
                    if (rxd_s_q) begin
                        if (!out_valid_q) begin
                            out_data_d  = rx_shift_q;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end

        rxr_n_d = out_valid_d;
    end

    // State registers with asynchronous reset; synchronisers idle high
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_cnt_q   <= 16'd0;
            sclk_q      <= 1'b0;
            txr_meta_q  <= 1'b1;
            txr_s_q     <= 1'b1;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            tx_state_q  <= TX_IDLE;
            txd_q       <= 1'b1;
            tx_shift_q  <= 8'd0;
            tx_cnt_q    <= 3'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_shift_q  <= 8'd0;
            rx_cnt_q    <= 3'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            rxr_n_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            sclk_q      <= sclk_d;
            txr_meta_q  <= sci_txr_n;
            txr_s_q     <= txr_meta_q;
            rxd_meta_q  <= sci_rxd;
            rxd_s_q     <= rxd_meta_q;
            tx_state_q  <= tx_state_d;
            txd_q       <= txd_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            in_ready_q  <= in_ready_d;
            rx_state_q  <= rx_state_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rxr_n_q     <= rxr_n_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sci_sclk     = sclk_q;
    assign sci_txd      = txd_q;
    assign sci_rxr_n    = rxr_n_q;
    assign in_ready     = in_ready_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_sci_host_master.sv
// Directed bench for sci_host_master with CLKDIV=4 (sclk period 8 clk).
// Expected TX bits and RX bytes go into queues when stimulus is driven and
// are popped when the DUT produces the corresponding output.
module tb_sci_host_master;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       sci_sclk;
    logic       sci_txd;
    logic       sci_txr_n = 1'b1;
    logic       sci_rxd = 1'b1;
    logic       sci_rxr_n;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overrun;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic       txq[$];
    logic [7:0] rxq[$];

    sci_host_master #(.CLKDIV(4)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sci_sclk     (sci_sclk),
        .sci_txd      (sci_txd),
        .sci_txr_n    (sci_txr_n),
        .sci_rxd      (sci_rxd),
        .sci_rxr_n    (sci_rxr_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk_clk = ~clk_clk;

    // Count error/overrun pulse cycles
    always @(posedge clk_clk) begin
        if (rx_frame_err === 1'b1) fe_cnt++;
        if (rx_overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until sclk transitions to lvl
    task automatic wait_edge(input logic lvl, output bit ok);
        logic prev;
        ok = 1'b0;
        prev = sci_sclk;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev !== lvl && sci_sclk === lvl) begin
                ok = 1'b1;
                return;
            end
            prev = sci_sclk;
        end
        check("sclk_edge_timeout", 1, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready === 1'b1) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("in_ready_timeout", 0, 1);
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) txq.push_back(b[i]);
        txq.push_back(1'b1);
        $display("tx accept byte=0x%02h", b);
    endtask

    task automatic wait_txd_start(input int limit, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        while (cyc < limit) begin
            tick();
            cyc++;
            if (sci_txd === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
        check("txd_start_timeout", 1, 0);
    endtask

    // Sample the 10 frame bits at successive sclk rises and compare with the queue
    task automatic check_tx_frame(input string tag);
        bit ok;
        logic exp;
        for (int i = 0; i < 10; i++) begin
            wait_edge(1'b1, ok);
            if (!ok) return;
            exp = (txq.size() > 0) ? txq.pop_front() : 1'bx;
            check($sformatf("%s_bit%0d", tag, i), sci_txd, exp);
        end
        $display("tx frame %s sampled", tag);
    endtask

    // Core side: change rxd on sclk falls, start/8 data/stop, then idle
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        bit ok;
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bitv = 1'b0;
            else if (i == 9) bitv = stop;
            else bitv = b[i-1];
            wait_edge(1'b0, ok);
            if (!ok) return;
            sci_rxd = bitv;
        end
        wait_edge(1'b0, ok);
        sci_rxd = 1'b1;
        $display("rx frame driven byte=0x%02h stop=%0d", b, stop);
    endtask

    initial begin
        int cyc;
        int n;
        int fe0;
        int ov0;
        bit ok;
        bit seen0;
        logic [7:0] expb;

        // 1: reset values, release, divider rate
        tick(); tick(); tick();
        check("rst_sclk", sci_sclk, 0);
        check("rst_txd", sci_txd, 1);
        check("rst_rxr_n", sci_rxr_n, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset_reset = 1'b0;
        tick(); tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_rxr_n", sci_rxr_n, 0);
        check("rel_txd", sci_txd, 1);
        wait_edge(~sci_sclk, ok);
        n = 0;
        begin
            logic s0;
            s0 = sci_sclk;
            for (int i = 0; i < 20 && sci_sclk === s0; i++) begin
                tick();
                n++;
            end
        end
        check("sclk_half_period", n, 4);

        // 2: ready core, send 0xA5
        sci_txr_n = 1'b0;
        tick(); tick(); tick(); tick();
        send_byte(8'hA5);
        check("hold_full_in_ready", in_ready, 0);
        wait_txd_start(40, cyc, ok);
        if (ok) begin
            check("in_ready_on_start", in_ready, 1);
            check_tx_frame("a5");
        end

        // 3: core not ready gates the frame
        sci_txr_n = 1'b1;
        tick(); tick(); tick(); tick();
        send_byte(8'h3C);
        seen0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sci_txd === 1'b0) seen0 = 1'b1;
        end
        check("txd_gated", seen0, 0);
        sci_txr_n = 1'b0;
        wait_txd_start(40, cyc, ok);
        if (ok) begin
            check("gate_release_latency_ok", (cyc <= 18), 1);
            check_tx_frame("3c");
        end
        check("txq_drained", txq.size(), 0);

        // 4: good rx frame
        rxq.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1);
        check("rx_valid", out_valid, 1);
        expb = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
        check("rx_data", out_data, expb);
        check("rx_rxr_n_full", sci_rxr_n, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rx_consumed", out_valid, 0);
        check("rx_rxr_n_empty", sci_rxr_n, 0);
        $display("rx consume byte=0x%02h", expb);

        // 5: framing error
        fe0 = fe_cnt;
        drive_frame(8'h11, 1'b0);
        tick(); tick();
        check("frame_err_pulse", fe_cnt - fe0, 1);
        check("frame_err_no_load", out_valid, 0);

        // 6: overrun
        ov0 = ov_cnt;
        rxq.push_back(8'h01);
        drive_frame(8'h01, 1'b1);
        drive_frame(8'h02, 1'b1);
        tick(); tick();
        check("overrun_pulse", ov_cnt - ov0, 1);
        check("overrun_valid", out_valid, 1);
        expb = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
        check("overrun_kept", out_data, expb);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("overrun_consumed", out_valid, 0);
        $display("rx consume byte=0x%02h", expb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
